// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared types and constants for the SPI mode-0 register-write controller.
//   state_e      : controller FSM states
//   FRAME_W etc. : frame field widths ({rw, addr[6:0], data[7:0]})
//   EN_OUT_* ... : spi_peripheral register addresses
//   pack_frame   : builds a 16-bit frame from its fields
//   max3         : elaboration helper for sizing shared counters
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'h04;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_ctrl_tx_if.sv
// -----------------------------------------------------------------------------
// spi_ctrl_tx_if
// Request handshake plus SPI pins of the controller.
//   req_valid/req_ready/req_rw/req_addr/req_data : frame request handshake
//   busy, done                                   : status (done = 1-cycle pulse)
//   SCLK, nCS, COPI                              : SPI bus driven by the controller
//   CIPO, rx_data                                : only with SPI_CTRL_CIPO_EN
// Modports: master = controller side, slave = requester / bus-observer side.
// -----------------------------------------------------------------------------
interface spi_ctrl_tx_if;
  import spi_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              busy;
  logic              done;
  logic              SCLK;
  logic              nCS;
  logic              COPI;
`ifdef SPI_CTRL_CIPO_EN
  logic               CIPO;
  logic [FRAME_W-1:0] rx_data;
`endif

  modport master (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready, busy, done, SCLK, nCS, COPI
`ifdef SPI_CTRL_CIPO_EN
    , input CIPO
    , output rx_data
`endif
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready, busy, done, SCLK, nCS, COPI
`ifdef SPI_CTRL_CIPO_EN
    , output CIPO
    , input  rx_data
`endif
  );

endinterface

// File: rtl/spi_ctrl_clkgen.sv
// -----------------------------------------------------------------------------
// spi_ctrl_clkgen
// SCLK half-period divider. While en_i is high it counts 0..CLK_DIV-1 per
// half-period, low phase first; while en_i is low it is held cleared.
//   clk, reset   : system clock, async active-low reset
//   en_i         : enable (controller is in SHIFT)
//   rise_tick_o  : last cycle of a low half-period (SCLK goes high next)
//   fall_tick_o  : last cycle of a high half-period (SCLK goes low next)
// -----------------------------------------------------------------------------
module spi_ctrl_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;   // 0 = SCLK low half, 1 = high half
  logic             last_s;

  assign last_s      = en_i && (div_q == DIV_LAST);
  assign rise_tick_o = last_s && !phase_q;
  assign fall_tick_o = last_s &&  phase_q;

  // divider next-state
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!en_i) begin
      div_d   = {DIV_W{1'b0}};
      phase_d = 1'b0;
    end else if (last_s) begin
      div_d   = {DIV_W{1'b0}};
      phase_d = ~phase_q;
    end else begin
      div_d   = div_q + DIV_W'(1);
    end
  end

  // divider registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= {DIV_W{1'b0}};
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_ctrl_tx.sv
// -----------------------------------------------------------------------------
// spi_ctrl_tx
// SPI mode-0 controller that serialises 16-bit {rw, addr, data} register-write
// frames MSB first. COPI changes after SCLK falls; the peripheral samples on
// SCLK rises.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low reset (aborts a frame immediately)
//   bus    : spi_ctrl_tx_if.master (request handshake, busy/done, SCLK/nCS/COPI)
// Parameters: CLK_DIV (>=2), CS_SETUP (>=1), CS_HOLD (>=1), CS_GAP (>=3).
// Build option: SPI_CTRL_CIPO_EN adds CIPO sampling on each SCLK rise and the
//   16-bit rx_data result, updated in the done cycle.
// -----------------------------------------------------------------------------
module spi_ctrl_tx
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 4
) (
  input  logic             clk,
  input  logic             reset,
  spi_ctrl_tx_if.master    bus
);

  localparam int CNT_MAX = max3(CS_SETUP, CS_HOLD, CS_GAP);
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(FRAME_W);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_ctrl_tx: CLK_DIV must be >= 2");
  end
  if (CS_SETUP < 1) begin : g_bad_cs_setup
    $error("spi_ctrl_tx: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("spi_ctrl_tx: CS_HOLD must be >= 1");
  end
  if (CS_GAP < 3) begin : g_bad_cs_gap
    $error("spi_ctrl_tx: CS_GAP must be >= 3");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // SETUP / HOLD / GAP dwell counter
  logic [BIT_W-1:0]   bit_q, bit_d;       // SCLK rises so far, 0..16
  logic [FRAME_W-1:0] shift_q, shift_d;   // COPI is always shift_q[15]
  logic               sclk_q, sclk_d;
  logic               ncs_q, ncs_d;
  logic               done_q, done_d;
  logic               rise_tick_s, fall_tick_s;

  spi_ctrl_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk         (clk),
    .reset       (reset),
    .en_i        (state_q == SHIFT),
    .rise_tick_o (rise_tick_s),
    .fall_tick_o (fall_tick_s)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.SCLK      = sclk_q;
  assign bus.nCS       = ncs_q;
  assign bus.COPI      = shift_q[FRAME_W-1];

  // FSM next-state and registered-output next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // the frame is captured here; later req_* changes cannot reach it
          shift_d = pack_frame(bus.req_rw, bus.req_addr, bus.req_data);
          ncs_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = SHIFT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (rise_tick_s) begin
          sclk_d = 1'b1;
          bit_d  = bit_q + BIT_W'(1);
        end else if (fall_tick_s) begin
          sclk_d = 1'b0;
          if (bit_q < BITS_ALL) begin
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          end else begin
            // 16th fall: bit 0 stays on COPI through HOLD
            cnt_d   = {CNT_W{1'b0}};
            state_d = HOLD;
          end
        end else begin
          sclk_d = sclk_q;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ncs_d   = 1'b1;
          shift_d = {FRAME_W{1'b0}};
          done_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = GAP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
        bit_d   = {BIT_W{1'b0}};
        shift_d = {FRAME_W{1'b0}};
        sclk_d  = 1'b0;
        ncs_d   = 1'b1;
      end
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      shift_q <= {FRAME_W{1'b0}};
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_CTRL_CIPO_EN
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;

  assign bus.rx_data = rx_data_q;

  // receive shift and result capture next values
  always_comb begin
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    if (rise_tick_s) begin
      rx_d = {rx_q[FRAME_W-2:0], bus.CIPO};
    end else begin
      rx_d = rx_q;
    end
    if (done_d) begin
      rx_data_d = rx_q;
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  // receive registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q      <= {FRAME_W{1'b0}};
      rx_data_q <= {FRAME_W{1'b0}};
    end else begin
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_ctrl_tx
// Directed bench for spi_ctrl_tx (CLK_DIV=4, CS_SETUP=4, CS_HOLD=4, CS_GAP=4)
// with a behavioural spi_peripheral register model on the SPI pins.
// -----------------------------------------------------------------------------
module tb_spi_ctrl_tx;
  import spi_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  spi_ctrl_tx_if intf();

  spi_ctrl_tx #(
    .CLK_DIV  (4),
    .CS_SETUP (4),
    .CS_HOLD  (4),
    .CS_GAP   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

`ifdef SPI_CTRL_CIPO_EN
  assign intf.CIPO = intf.COPI;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // behavioural spi_peripheral: samples COPI on SCLK rise, commits on nCS rise
  logic [7:0]  regs [0:4];
  logic [15:0] p_sh   = 16'h0000;
  int          p_bits = 0;
  int          rises  = 0;
  int          edge_bad = 0;

  always @(posedge intf.SCLK or posedge intf.nCS or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) regs[i] = 8'h00;
      p_bits = 0;
    end else if (intf.nCS) begin
      if (p_bits == 16 && p_sh[15] && p_sh[14:8] < 7'd5) regs[p_sh[14:8]] = p_sh[7:0];
      p_bits = 0;
    end else begin
      p_sh = {p_sh[14:0], intf.COPI};
      p_bits++;
      rises++;
    end
  end

  // SCLK must never move while nCS is high
  always @(intf.SCLK) begin
    if (reset && intf.nCS === 1'b1) edge_bad++;
  end

  // cycle monitor
  int          cyc = 0;
  int          done_cnt = 0;
  int          ncs_low = 0;
  int          ready_bad = 0;
  int          acc_cyc[$];
  int          done_cyc[$];
  logic [15:0] frames[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      if (intf.done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        frames.push_back(p_sh);
      end
      if (intf.req_valid && intf.req_ready) acc_cyc.push_back(cyc);
      if (!intf.nCS) ncs_low++;
      if (!intf.nCS && intf.req_ready) ready_bad++;
    end
  end

  task automatic start_req(input logic [15:0] f);
    @(negedge clk);
    intf.req_valid = 1'b1;
    intf.req_rw    = f[15];
    intf.req_addr  = f[14:8];
    intf.req_data  = f[7:0];
  endtask

  // returns just after the accepting edge
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!intf.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq(tag, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n = 0;
    while (rises < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_ncs"},   intf.nCS,       32'd1);
    check_eq({pfx, "_sclk"},  intf.SCLK,      32'd0);
    check_eq({pfx, "_copi"},  intf.COPI,      32'd0);
    check_eq({pfx, "_busy"},  intf.busy,      32'd0);
    check_eq({pfx, "_done"},  intf.done,      32'd0);
    check_eq({pfx, "_ready"}, intf.req_ready, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_ncs, b_r, b_d, b_f, a0, d0;

    intf.req_valid = 1'b0;
    intf.req_rw    = 1'b0;
    intf.req_addr  = 7'h00;
    intf.req_data  = 8'h00;

    // reset state
    #1 reset = 1'b0;
    #3;
    check_idle_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_rst");

    // single write {1, PWM_DUTY, 8'h80}
    b_ncs = ncs_low; b_r = rises; b_d = done_cnt; b_f = frames.size();
    start_req(16'h8480);
    wait_accept("t2_accept_timeout");
    intf.req_valid = 1'b0;
    check_eq("t2_busy",  intf.busy,      32'd1);
    check_eq("t2_ready", intf.req_ready, 32'd0);
    check_eq("t2_ncs",   intf.nCS,       32'd0);
    check_eq("t2_copi0", intf.COPI,      32'd1);
    wait_done(b_d + 1, "t2_done_timeout");
    repeat (6) @(negedge clk);
    check_eq("t2_frame",   frames[b_f],    32'h8480);
    check_eq("t2_rises",   rises - b_r,    32'd16);
    check_eq("t2_ncs_low", ncs_low - b_ncs, 32'd136);
    check_eq("t2_dones",   done_cnt - b_d, 32'd1);
    check_eq("t2_reg4",    regs[4],        32'h80);
    check_eq("t2_ready_back", intf.req_ready, 32'd1);

    // back-to-back requests held valid
    b_ncs = ncs_low; b_r = rises; b_d = done_cnt; b_f = frames.size();
    a0 = acc_cyc.size(); d0 = done_cyc.size();
    start_req(16'h8111);
    wait_accept("t3_acc1_timeout");
    @(negedge clk);
    intf.req_addr = 7'h02;
    intf.req_data = 8'h22;
    wait_accept("t3_acc2_timeout");
    intf.req_valid = 1'b0;
    wait_done(b_d + 2, "t3_done_timeout");
    repeat (6) @(negedge clk);
    check_eq("t3_period",      acc_cyc[a0 + 1] - acc_cyc[a0],  32'd141);
    check_eq("t3_done_to_acc", acc_cyc[a0 + 1] - done_cyc[d0], 32'd4);
    check_eq("t3_rises",       rises - b_r,     32'd32);
    check_eq("t3_ncs_low",     ncs_low - b_ncs, 32'd272);
    check_eq("t3_frame0",      frames[b_f],     32'h8111);
    check_eq("t3_frame1",      frames[b_f + 1], 32'h8222);

    // request fields changing while the frame shifts out
    b_d = done_cnt; b_f = frames.size(); b_r = rises;
    start_req(16'h82A5);
    wait_accept("t4_accept_timeout");
    intf.req_valid = 1'b0;
    wait_rises(b_r + 3, "t4_rise_timeout");
    @(negedge clk);
    intf.req_data = 8'h00;
    intf.req_addr = 7'h7F;
    check_eq("t4_ready_mid", intf.req_ready, 32'd0);
    wait_done(b_d + 1, "t4_done_timeout");
    repeat (6) @(negedge clk);
    check_eq("t4_frame",     frames[b_f], 32'h82A5);
    check_eq("t4_reg2",      regs[2],     32'hA5);
    check_eq("t4_ready_bad", ready_bad,   32'd0);

    // reset in the middle of a frame, then a fresh write
    b_d = done_cnt; b_r = rises;
    start_req(16'h813C);
    wait_accept("t5_accept_timeout");
    intf.req_valid = 1'b0;
    wait_rises(b_r + 7, "t5_rise_timeout");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_ncs",   intf.nCS,       32'd1);
    check_eq("t5_sclk",  intf.SCLK,      32'd0);
    check_eq("t5_copi",  intf.COPI,      32'd0);
    check_eq("t5_busy",  intf.busy,      32'd0);
    check_eq("t5_ready", intf.req_ready, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5_no_done", done_cnt - b_d, 32'd0);
    start_req(16'h80FF);
    wait_accept("t5b_accept_timeout");
    intf.req_valid = 1'b0;
    wait_done(b_d + 1, "t5b_done_timeout");
    repeat (6) @(negedge clk);
    check_eq("t5_reg0", regs[0], 32'hFF);
    for (int i = 1; i < 5; i++) check_eq($sformatf("t5_reg%0d", i), regs[i], 32'h00);

    // write 8'hC3 to EN_PWM_15_8; with CIPO looped back rx_data echoes the frame
    b_d = done_cnt;
    start_req(16'h83C3);
    wait_accept("t6_accept_timeout");
    intf.req_valid = 1'b0;
    wait_done(b_d + 1, "t6_done_timeout");
    repeat (2) @(negedge clk);
    check_eq("t6_reg3", regs[3], 32'hC3);
`ifdef SPI_CTRL_CIPO_EN
    check_eq("t6_rx_data", intf.rx_data, 32'h83C3);
`endif

    check_eq("sclk_edge_with_ncs_high", edge_bad, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
